// File: rtl/updown_counter_pkg.sv
// ============================================================================
// Module   : updown_counter_pkg
// Purpose  : Shared constants for the up/down counter (limit-behaviour modes).
// Revision : 1.0
// ============================================================================
`default_nettype none

package updown_counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
// Module   : updown_counter_mod
// Purpose  : Up/down counter, programmable modulus, load/clear, wrap or
//            saturate at the limits, terminal-count and sticky event flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;

    logic w_at_max, w_at_zero, w_sat, w_wrap;

    assign w_at_max  = (count_q == C_MAX);
    assign w_at_zero = (count_q == '0);
    assign w_sat     = (mode == MODE_SAT);
    assign w_wrap    = (mode == MODE_WRAP);

    // Limits are compared against C_MAX explicitly so non-power-of-2 moduli work.
    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        ovf_sticky_d = ovf_sticky_q & ~flag_clr;
        unf_sticky_d = unf_sticky_q & ~flag_clr;

        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > C_MAX) ? C_MAX : load_val;
        end else if (en) begin
            if (up_down) begin
                if (!w_at_max) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    ovf_sticky_d = 1'b1;
                    if (w_wrap) begin
                        count_d      = '0;
                        wrap_pulse_d = 1'b1;
                    end else if (w_sat) begin
                        count_d = C_MAX;
                    end
                end
            end else begin
                if (!w_at_zero) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    unf_sticky_d = 1'b1;
                    if (w_wrap) begin
                        count_d      = C_MAX;
                        wrap_pulse_d = 1'b1;
                    end else if (w_sat) begin
                        count_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            wrap_pulse_q <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    // Combinational so a downstream stage can enable on the same edge.
    assign tc = en & ~clear & ~load &
                ((up_down & w_at_max) | (~up_down & w_at_zero));

    assign count      = count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
// Module   : tb_updown_counter_mod
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            randomized stimulus against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;

    localparam int MODA = 10;
    localparam int MAXA = MODA - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 0, up_down = 0, mode = 0, clear = 0, load = 0, flag_clr = 0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       tc, wrap_pulse, ovf_sticky, unf_sticky;

    logic       b_en = 0, b_up_down = 0, b_mode = 0, b_clear = 0, b_load = 0, b_flag_clr = 0;
    logic [7:0] b_load_val = '0;
    logic [7:0] b_count;
    logic       b_tc, b_wrap_pulse, b_ovf_sticky, b_unf_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MODULUS(MODA)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .mode(mode),
        .clear(clear), .load(load), .load_val(load_val), .flag_clr(flag_clr),
        .count(count), .tc(tc), .wrap_pulse(wrap_pulse),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    updown_counter_mod #(.WIDTH(8), .MODULUS(256)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(b_en), .up_down(b_up_down), .mode(b_mode),
        .clear(b_clear), .load(b_load), .load_val(b_load_val), .flag_clr(b_flag_clr),
        .count(b_count), .tc(b_tc), .wrap_pulse(b_wrap_pulse),
        .ovf_sticky(b_ovf_sticky), .unf_sticky(b_unf_sticky)
    );

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d] actual %0d expected %0d", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       en, ud, md, clr, ld;
        logic [3:0] lv;
        logic       fc;
        logic       tc;
        int         cnt;
        logic       wr, ov, un;
    } vec_t;

    function automatic vec_t mk(logic e, logic u, logic m, logic c, logic l, int v,
                                logic f, logic t, int n, logic w, logic o, logic un);
        vec_t r;
        r.en = e; r.ud = u; r.md = m; r.clr = c; r.ld = l; r.lv = 4'(v); r.fc = f;
        r.tc = t; r.cnt = n; r.wr = w; r.ov = o; r.un = un;
        return r;
    endfunction

    vec_t vecs[$];

    // Reference model state: plain integers, modular arithmetic.
    int m_count, m_wrap, m_ovf, m_unf;

    function automatic int model_tc(int e, int u, int c, int l);
        return (e && !c && !l && ((u && m_count == MAXA) || (!u && m_count == 0))) ? 1 : 0;
    endfunction

    task automatic model_step(int e, int u, int md, int c, int l, int v, int f);
        int set_o, set_u;
        set_o = 0; set_u = 0; m_wrap = 0;
        if (c) m_count = 0;
        else if (l) m_count = (v > MAXA) ? MAXA : v;
        else if (e) begin
            if (u) begin
                set_o = (m_count + 1 > MAXA);
                if (md) m_count = (m_count + 1 > MAXA) ? MAXA : m_count + 1;
                else begin
                    m_wrap  = set_o;
                    m_count = (m_count + 1) % MODA;
                end
            end else begin
                set_u = (m_count - 1 < 0);
                if (md) m_count = (m_count - 1 < 0) ? 0 : m_count - 1;
                else begin
                    m_wrap  = set_u;
                    m_count = (m_count - 1 + MODA) % MODA;
                end
            end
        end
        m_ovf = set_o ? 1 : (f ? 0 : m_ovf);
        m_unf = set_u ? 1 : (f ? 0 : m_unf);
    endtask

    initial begin
        // ---------- reset state ----------
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 0, int'(count), 0);
        chk("reset_flags", 0, int'({wrap_pulse, ovf_sticky, unf_sticky}), 0);
        chk("reset_b_count", 0, int'(b_count), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------- 8-bit full-range wrap on the second instance ----------
        b_en = 1; b_up_down = 0; b_mode = 0;
        #1 chk("b_tc_down0", 0, int'(b_tc), 1);
        @(posedge clk); #1;
        chk("b_down_wrap_count", 0, int'(b_count), 255);
        chk("b_down_wrap_pulse", 0, int'(b_wrap_pulse), 1);
        chk("b_unf", 0, int'(b_unf_sticky), 1);
        b_up_down = 1;
        #1 chk("b_tc_up255", 0, int'(b_tc), 1);
        @(posedge clk); #1;
        chk("b_up_wrap_count", 0, int'(b_count), 0);
        chk("b_up_wrap_pulse", 0, int'(b_wrap_pulse), 1);
        chk("b_ovf", 0, int'(b_ovf_sticky), 1);
        b_en = 0;

        // ---------- directed vector table (MAX = 9) ----------
        //           en ud md clr ld val fc | tc cnt wr ov un
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, k, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,  2, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 13, 0, 0, 9, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1,  5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1,  5, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 6, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 7, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 6, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1,  9, 0, 0, 9, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 9, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0,  0, 1, 1, 9, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 9, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1,  3, 0, 0, 3, 0, 1, 1));

        foreach (vecs[i]) begin
            en = vecs[i].en; up_down = vecs[i].ud; mode = vecs[i].md;
            clear = vecs[i].clr; load = vecs[i].ld; load_val = vecs[i].lv;
            flag_clr = vecs[i].fc;
            #1 chk("vec_tc", i, int'(tc), int'(vecs[i].tc));
            @(posedge clk); #1;
            chk("vec_count", i, int'(count), vecs[i].cnt);
            chk("vec_wrap", i, int'(wrap_pulse), int'(vecs[i].wr));
            chk("vec_ovf", i, int'(ovf_sticky), int'(vecs[i].ov));
            chk("vec_unf", i, int'(unf_sticky), int'(vecs[i].un));
        end

        // ---------- asynchronous reset mid-count ----------
        en = 1; up_down = 1; mode = 0; clear = 0; load = 0; flag_clr = 0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", 0, int'(count), 0);
        chk("async_rst_flags", 0, int'({wrap_pulse, ovf_sticky, unf_sticky}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_count", 0, int'(count), 1);

        // ---------- randomized run against the model ----------
        m_count = 1; m_wrap = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < 500; i++) begin
            int e, u, md, c, l, v, f;
            e  = ($urandom_range(3) != 0);
            u  = $urandom_range(1);
            md = $urandom_range(1);
            c  = ($urandom_range(15) == 0);
            l  = ($urandom_range(7) == 0);
            v  = $urandom_range(15);
            f  = ($urandom_range(7) == 0);
            en = 1'(e); up_down = 1'(u); mode = 1'(md); clear = 1'(c);
            load = 1'(l); load_val = 4'(v); flag_clr = 1'(f);
            #1 chk("rnd_tc", i, int'(tc), model_tc(e, u, c, l));
            @(posedge clk); #1;
            model_step(e, u, md, c, l, v, f);
            chk("rnd_count", i, int'(count), m_count);
            chk("rnd_wrap", i, int'(wrap_pulse), m_wrap);
            chk("rnd_ovf", i, int'(ovf_sticky), m_ovf);
            chk("rnd_unf", i, int'(unf_sticky), m_unf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
